pcler_cnt: RTL and testbench

PCLER_CNT -- requirements
Module: pcler_cnt

---
 rtl/pcler_pkg.sv | 14 +
 rtl/pcler_cnt_next.sv | 58 +++++
 rtl/pcler_cnt.sv | 61 ++++++
 tb/tb_pcler_cnt.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pcler_pkg.sv
// Shared constants and helpers for the pcler counter family.
package pcler_pkg;

    // Behaviour at the terminal value: wrap around or stick.
    localparam int SAT_WRAP = 0;
    localparam int SAT_HOLD = 1;

    // Limit a value to the terminal value; operands are zero-extended to 32 bits.
    function automatic logic [31:0] clip_to_max(input logic [31:0] val,
                                                input logic [31:0] max_val);
        return (val > max_val) ? max_val : val;
    endfunction

endpackage

// File: rtl/pcler_cnt_next.sv
// Next-state, terminal-count and wrap-event logic for pcler_cnt (purely combinational).
module pcler_cnt_next
    import pcler_pkg::*;
#(
    parameter int          WIDTH   = 8,
    parameter int unsigned MAX_VAL = 32'((64'd1 << WIDTH) - 64'd1),
    parameter int          SAT     = SAT_WRAP
) (
    input  logic [WIDTH-1:0] q_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             en_i,
    input  logic             inh_i,
    input  logic             cin_i,
    input  logic             up_i,
    output logic [WIDTH-1:0] q_d_o,
    output logic             wrap_d_o,
    output logic             tc_o,
    output logic             cout_o
);

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_VAL);

    logic             step;
    logic             clip;
    logic [WIDTH-1:0] din_clipped;

    // Priority clr > load > step > hold; wrap event flags a clipped load or a
    // step taken while sitting on the terminal value of the current direction.
    always_comb begin
        step        = en_i & ~inh_i & cin_i;
        tc_o        = up_i ? (q_i == MAX_Q) : (q_i == '0);
        cout_o      = tc_o & step;
        clip        = (din_i > MAX_Q);
        din_clipped = WIDTH'(clip_to_max(32'(din_i), MAX_VAL));
        q_d_o       = q_i;
        wrap_d_o    = 1'b0;
        if (clr_i) begin
            q_d_o = '0;
        end else if (load_i) begin
            q_d_o    = din_clipped;
            wrap_d_o = clip;
        end else if (step) begin
            wrap_d_o = tc_o;
            if (tc_o) begin
                if (SAT == SAT_HOLD) begin
                    q_d_o = q_i;
                end else begin
                    q_d_o = up_i ? '0 : MAX_Q;
                end
            end else begin
                q_d_o = up_i ? (q_i + WIDTH'(1)) : (q_i - WIDTH'(1));
            end
        end
    end

endmodule

// File: rtl/pcler_cnt.sv
// Cascadable up/down counter with clear, clipped parallel load, wrap or
// saturate at MAX_VAL, and a registered wrap/saturation event pulse.
module pcler_cnt
    import pcler_pkg::*;
#(
    parameter int          WIDTH   = 8,
    parameter int unsigned MAX_VAL = 32'((64'd1 << WIDTH) - 64'd1),
    parameter int          SAT     = SAT_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             en,
    input  logic             inh,
    input  logic             cin,
    input  logic             up,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             cout,
    output logic             wrap_evt
);

    logic [WIDTH-1:0] q_q, q_d;
    logic             wrap_q, wrap_d;

    pcler_cnt_next #(
        .WIDTH   (WIDTH),
        .MAX_VAL (MAX_VAL),
        .SAT     (SAT)
    ) u_next (
        .q_i      (q_q),
        .clr_i    (clr),
        .load_i   (load),
        .din_i    (din),
        .en_i     (en),
        .inh_i    (inh),
        .cin_i    (cin),
        .up_i     (up),
        .q_d_o    (q_d),
        .wrap_d_o (wrap_d),
        .tc_o     (tc),
        .cout_o   (cout)
    );

    // Count and event registers; reset takes effect immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q    <= '0;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
        end
    end

    assign q        = q_q;
    assign wrap_evt = wrap_q;

endmodule

// File: tb/tb_pcler_cnt.sv
// Bench for pcler_cnt: three single counters share one stimulus stream and are
// checked against an arithmetic reference model; a 2-stage cascade runs apart.
module tb_pcler_cnt;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr, load, en, inh, cin, up;
  logic [7:0] din;

  logic [7:0] q8;
  logic [3:0] q4s, q4w;
  logic       tc8, tc4s, tc4w, co8, co4s, co4w, w8, w4s, w4w;

  logic       c_clr, c_en;
  logic [3:0] lo_q, hi_q;
  logic       lo_tc, lo_cout, lo_wrap, hi_tc, hi_cout, hi_wrap;

  int n_checks = 0;
  int n_err    = 0;

  // reference model state, one entry per single counter
  longint m_q  [3];
  bit     m_w  [3];
  longint MAXV [3] = '{255, 9, 9};
  bit     SATV [3] = '{1'b0, 1'b1, 1'b0};
  longint DMASK[3] = '{255, 15, 15};

  typedef struct {
    bit         c, l;
    logic [7:0] d;
    bit         e, ih, ci, u;
    longint     eq;
    bit         ew;
  } vec_t;
  vec_t tbl[15];

  always #5 clk = ~clk;

  pcler_cnt #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .din(din), .en(en), .inh(inh),
    .cin(cin), .up(up), .q(q8), .tc(tc8), .cout(co8), .wrap_evt(w8));

  pcler_cnt #(.WIDTH(4), .MAX_VAL(9), .SAT(1)) u4s (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .din(din[3:0]), .en(en), .inh(inh),
    .cin(cin), .up(up), .q(q4s), .tc(tc4s), .cout(co4s), .wrap_evt(w4s));

  pcler_cnt #(.WIDTH(4), .MAX_VAL(9), .SAT(0)) u4w (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .din(din[3:0]), .en(en), .inh(inh),
    .cin(cin), .up(up), .q(q4w), .tc(tc4w), .cout(co4w), .wrap_evt(w4w));

  pcler_cnt #(.WIDTH(4)) u_lo (
    .clk(clk), .rst(rst), .clr(c_clr), .load(1'b0), .din(4'd0), .en(c_en), .inh(1'b0),
    .cin(1'b1), .up(1'b1), .q(lo_q), .tc(lo_tc), .cout(lo_cout), .wrap_evt(lo_wrap));

  pcler_cnt #(.WIDTH(4)) u_hi (
    .clk(clk), .rst(rst), .clr(c_clr), .load(1'b0), .din(4'd0), .en(c_en), .inh(1'b0),
    .cin(lo_cout), .up(1'b1), .q(hi_q), .tc(hi_tc), .cout(hi_cout), .wrap_evt(hi_wrap));

  function automatic logic [63:0] dut_q(input int i);
    return (i == 0) ? 64'(q8) : (i == 1) ? 64'(q4s) : 64'(q4w);
  endfunction
  function automatic logic [63:0] dut_tc(input int i);
    return (i == 0) ? 64'(tc8) : (i == 1) ? 64'(tc4s) : 64'(tc4w);
  endfunction
  function automatic logic [63:0] dut_co(input int i);
    return (i == 0) ? 64'(co8) : (i == 1) ? 64'(co4s) : 64'(co4w);
  endfunction
  function automatic logic [63:0] dut_w(input int i);
    return (i == 0) ? 64'(w8) : (i == 1) ? 64'(w4s) : 64'(w4w);
  endfunction

  // Counter behaviour stated as modular / clamped arithmetic on integers.
  function automatic void model_next(input longint q, input longint mx, input bit sat,
                                     input bit c, input bit l, input longint d,
                                     input bit s, input bit u,
                                     output longint nq, output bit evt);
    nq  = q;
    evt = 1'b0;
    if (c) begin
      nq = 0;
    end else if (l) begin
      nq  = (d > mx) ? mx : d;
      evt = (d > mx);
    end else if (s) begin
      evt = u ? (q == mx) : (q == 0);
      if (u) nq = sat ? ((q + 1 > mx) ? mx : q + 1) : (q + 1) % (mx + 1);
      else   nq = sat ? ((q == 0) ? 0 : q - 1) : (q + mx) % (mx + 1);
    end
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, check combinational outputs, clock, check registers.
  task automatic cycle(input bit c, input bit l, input logic [7:0] d,
                       input bit e, input bit ih, input bit ci, input bit u);
    bit     s, tcm, evt;
    longint nq;
    clr = c; load = l; din = d; en = e; inh = ih; cin = ci; up = u;
    #1;
    s = e & ~ih & ci;
    for (int i = 0; i < 3; i++) begin
      tcm = u ? (m_q[i] == MAXV[i]) : (m_q[i] == 0);
      chk($sformatf("tc[%0d]", i), dut_tc(i), 64'(tcm));
      chk($sformatf("cout[%0d]", i), dut_co(i), 64'(tcm & s));
    end
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      model_next(m_q[i], MAXV[i], SATV[i], c, l, longint'(d) & DMASK[i], s, u, nq, evt);
      m_q[i] = nq;
      m_w[i] = evt;
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("q[%0d]", i), dut_q(i), 64'(m_q[i]));
      chk($sformatf("wrap_evt[%0d]", i), dut_w(i), 64'(m_w[i]));
    end
  endtask

  task automatic rst_pulse();
    clr = 0; load = 0; en = 0;
    #2;
    rst = 1'b1;
    #2;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_q[%0d]", i), dut_q(i), 64'd0);
      chk($sformatf("rst_wrap[%0d]", i), dut_w(i), 64'd0);
      m_q[i] = 0;
      m_w[i] = 1'b0;
    end
    rst = 1'b0;
  endtask

  initial begin
    // clock/reset
    rst = 1'b1; clr = 0; load = 0; din = 0; en = 0; inh = 0; cin = 0; up = 1;
    c_clr = 0; c_en = 0;
    for (int i = 0; i < 3; i++) begin m_q[i] = 0; m_w[i] = 1'b0; end
    #2;
    chk("reset_q8", q8, 0);
    chk("reset_wrap8", w8, 0);
    chk("reset_tc_up", tc8, 0);
    up = 0;
    #1;
    chk("reset_tc_down", tc8, 1);
    chk("reset_lo_q", lo_q, 0);
    up = 1;
    #9;
    rst = 1'b0;
    @(posedge clk); #1;

    // cascade: high stage advances only when low stage carries out
    for (int k = 0; k < 20; k++) begin
      logic       lc;
      logic [3:0] hb;
      c_en = 1'b1;
      #1;
      lc = lo_cout;
      hb = hi_q;
      chk("casc_lo_cout", lc, 64'((k % 16) == 15));
      @(posedge clk); #1;
      chk("casc_hi_step", hi_q, 64'((longint'(hb) + longint'(lc)) % 16));
    end
    c_en = 1'b0;
    chk("casc_lo_final", lo_q, 4);
    chk("casc_hi_final", hi_q, 1);

    // table of directed vectors, expectations for the 8-bit counter
    tbl[0]  = '{0, 0, 8'd0,   1, 0, 1, 1,   1, 0};
    tbl[1]  = '{0, 0, 8'd0,   1, 0, 1, 1,   2, 0};
    tbl[2]  = '{0, 0, 8'd0,   1, 1, 1, 1,   2, 0};
    tbl[3]  = '{0, 0, 8'd0,   1, 0, 0, 1,   2, 0};
    tbl[4]  = '{0, 0, 8'd0,   1, 0, 1, 0,   1, 0};
    tbl[5]  = '{0, 1, 8'd200, 0, 0, 1, 0, 200, 0};
    tbl[6]  = '{1, 1, 8'd5,   1, 0, 1, 1,   0, 0};
    tbl[7]  = '{0, 1, 8'd5,   1, 0, 1, 1,   5, 0};
    tbl[8]  = '{0, 0, 8'd0,   1, 0, 1, 0,   4, 0};
    tbl[9]  = '{0, 1, 8'd255, 0, 0, 1, 0, 255, 0};
    tbl[10] = '{0, 0, 8'd0,   1, 0, 1, 1,   0, 1};
    tbl[11] = '{0, 0, 8'd0,   1, 0, 1, 0, 255, 1};
    tbl[12] = '{0, 0, 8'd0,   0, 0, 1, 0, 255, 0};
    tbl[13] = '{1, 0, 8'd0,   1, 0, 1, 1,   0, 0};
    tbl[14] = '{0, 1, 8'd255, 1, 0, 1, 1, 255, 0};
    cycle(1, 0, 8'd0, 0, 0, 0, 1);
    for (int i = 0; i < 15; i++) begin
      cycle(tbl[i].c, tbl[i].l, tbl[i].d, tbl[i].e, tbl[i].ih, tbl[i].ci, tbl[i].u);
      chk($sformatf("tbl_q[%0d]", i), q8, 64'(tbl[i].eq));
      chk($sformatf("tbl_wrap[%0d]", i), w8, 64'(tbl[i].ew));
    end

    // full 8-bit up count with wrap
    cycle(1, 0, 8'd0, 0, 0, 0, 1);
    for (int i = 0; i < 255; i++) cycle(0, 0, 8'd0, 1, 0, 1, 1);
    chk("full_q255", q8, 255);
    chk("full_tc", tc8, 1);
    chk("full_cout", co8, 1);
    cycle(0, 0, 8'd0, 1, 0, 1, 1);
    chk("full_wrap_q", q8, 0);
    chk("full_wrap_evt", w8, 1);

    // saturating 4-bit: clipped load, then sticky at MAX_VAL
    cycle(0, 1, 8'd12, 0, 0, 1, 1);
    chk("sat_load_q", q4s, 9);
    chk("sat_load_evt", w4s, 1);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 8'd0, 1, 0, 1, 1);
      chk("sat_hold_q", q4s, 9);
      chk("sat_hold_evt", w4s, 1);
    end

    // wrapping 4-bit: count down through zero to MAX_VAL
    cycle(0, 1, 8'd1, 0, 0, 1, 0);
    cycle(0, 0, 8'd0, 1, 0, 1, 0);
    chk("down_q0", q4w, 0);
    chk("down_tc", tc4w, 1);
    cycle(0, 0, 8'd0, 1, 0, 1, 0);
    chk("down_wrap_q", q4w, 9);
    chk("down_wrap_evt", w4w, 1);

    // asynchronous reset between edges
    cycle(0, 1, 8'd7, 0, 0, 1, 1);
    chk("pre_rst_q", q8, 7);
    rst_pulse();
    cycle(0, 1, 8'd255, 0, 0, 1, 1);
    chk("pre_rst_evt", w4s, 1);
    rst_pulse();
    cycle(0, 0, 8'd0, 1, 0, 1, 1);

    // randomized stimulus against the model
    for (int n = 0; n < 400; n++) begin
      cycle($urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0,
            8'($urandom_range(0, 255)), $urandom_range(0, 3) != 0,
            $urandom_range(0, 7) == 0, $urandom_range(0, 7) != 0,
            $urandom_range(0, 3) != 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
